ahb_lite_arbiter_2m: RTL and testbench

- Shares one AHB-Lite slave-side bus between two AHB-Lite masters (m0, m1), e.g. instruction-fetch and data ports.
- Multiplexes the address-phase signals of the owning master onto the slave bus.
- Stalls the non-owning master with HREADY low.
- Routes response signals back to the master whose data phase is active.
- Ownership is handed over only at idle boundaries, so no accepted transfer is lost or duplicated.

---
 rtl/ahb_lite_arbiter_2m.sv | 179 +++++++++++++++++
 tb/tb_ahb_lite_arbiter_2m.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_arbiter_2m.sv
// ----------------------------------------------------------------------------
// ahb_lite_arbiter_2m
//
// Lets two AHB-Lite masters (m0, m1) share one AHB-Lite slave bus.
// The owning master's address-phase signals and write data are muxed onto the
// slave bus. A non-owner that requests is stalled with HREADY low until
// ownership changes. Ownership changes only when the owner is IDLE and not
// locked, so an accepted transfer is never lost or duplicated.
//
// Ports
//   HCLK, HRESETn                 clock, asynchronous active-low reset
//   mN_HTRANS/HADDR/HWRITE/HSIZE/ master N address phase and write data
//   HBURST/HPROT/HMASTLOCK/HWDATA
//   mN_HREADY/HRESP/HRDATA        per-master response
//   s_HTRANS ... s_HWDATA         slave-side address phase and write data
//   s_HREADY/HRESP/HRDATA         slave-side response
//   owner_o                       current address-phase owner (arbiter state)
//   starve_o                      non-owner has waited >= STARVE_LIMIT cycles
//
// Handshake: a transfer is accepted at a rising HCLK where HTRANS is
// NONSEQ/SEQ on the slave bus and s_HREADY is 1. A stalled master sees
// HREADY = 0 and must hold its address-phase signals until HREADY = 1.
// ----------------------------------------------------------------------------
module ahb_lite_arbiter_2m #(
   parameter bit PARK_MASTER  = 1'b0,
   parameter int STARVE_LIMIT = 16
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   // master 0
   input  logic [1:0]  m0_HTRANS,
   input  logic [31:0] m0_HADDR,
   input  logic        m0_HWRITE,
   input  logic [2:0]  m0_HSIZE,
   input  logic [2:0]  m0_HBURST,
   input  logic [3:0]  m0_HPROT,
   input  logic        m0_HMASTLOCK,
   input  logic [31:0] m0_HWDATA,
   output logic        m0_HREADY,
   output logic [1:0]  m0_HRESP,
   output logic [31:0] m0_HRDATA,
   // master 1
   input  logic [1:0]  m1_HTRANS,
   input  logic [31:0] m1_HADDR,
   input  logic        m1_HWRITE,
   input  logic [2:0]  m1_HSIZE,
   input  logic [2:0]  m1_HBURST,
   input  logic [3:0]  m1_HPROT,
   input  logic        m1_HMASTLOCK,
   input  logic [31:0] m1_HWDATA,
   output logic        m1_HREADY,
   output logic [1:0]  m1_HRESP,
   output logic [31:0] m1_HRDATA,
   // slave side
   output logic [1:0]  s_HTRANS,
   output logic [31:0] s_HADDR,
   output logic        s_HWRITE,
   output logic [2:0]  s_HSIZE,
   output logic [2:0]  s_HBURST,
   output logic [3:0]  s_HPROT,
   output logic        s_HMASTLOCK,
   output logic [31:0] s_HWDATA,
   input  logic        s_HREADY,
   input  logic [1:0]  s_HRESP,
   input  logic [31:0] s_HRDATA,
   // status
   output logic        owner_o,
   output logic        starve_o
);

   localparam logic [1:0] LP_IDLE = 2'b00;
   localparam logic [1:0] LP_OKAY = 2'b00;
   localparam logic [7:0] LP_LIMIT = 8'(STARVE_LIMIT);
   localparam logic [7:0] LP_SAT   = 8'hFF;

   // Arbiter state: owner, whether a data phase of the owner is in flight,
   // and how long the non-owner has been waiting.
   logic       r_owner;
   logic       r_dphase_valid;
   logic [7:0] r_wait_cnt;

   logic       w_owner_nxt;
   logic       w_dphase_nxt;
   logic [7:0] w_wait_nxt;

   logic       w_req0;
   logic       w_req1;
   logic       w_req_own;
   logic       w_req_oth;
   logic       w_own_idle;
   logic       w_own_lock;
   logic       w_handover;
   logic       w_park;

   // BUSY (01) has HTRANS[1] = 0, so it is not a request.
   assign w_req0     = m0_HTRANS[1];
   assign w_req1     = m1_HTRANS[1];
   assign w_req_own  = r_owner ? w_req1 : w_req0;
   assign w_req_oth  = r_owner ? w_req0 : w_req1;
   assign w_own_idle = (r_owner ? m1_HTRANS : m0_HTRANS) == LP_IDLE;
   assign w_own_lock = r_owner ? m1_HMASTLOCK : m0_HMASTLOCK;

   // Ownership only moves at an idle, unlocked boundary of the owner and only
   // while the slave is ready; otherwise a pending data phase could be split.
   assign w_handover = s_HREADY && !w_own_lock && w_own_idle && w_req_oth;
   assign w_park     = s_HREADY && !w_own_lock && w_own_idle && !w_req0 && !w_req1
                       && (r_owner != PARK_MASTER);

   always_comb begin
      w_owner_nxt  = r_owner;
      w_dphase_nxt = r_dphase_valid;
      w_wait_nxt   = r_wait_cnt;
      if (w_handover) begin
         w_owner_nxt = ~r_owner;
      end else if (w_park) begin
         w_owner_nxt = PARK_MASTER;
      end
      // The transfer accepted at this edge belongs to the current owner.
      if (s_HREADY) begin
         w_dphase_nxt = w_req_own;
      end
      if (w_handover || !w_req_oth) begin
         w_wait_nxt = 8'd0;
      end else if (r_wait_cnt != LP_SAT) begin
         w_wait_nxt = r_wait_cnt + 8'd1;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_owner        <= PARK_MASTER;
         r_dphase_valid <= 1'b0;
         r_wait_cnt     <= 8'd0;
      end else begin
         r_owner        <= w_owner_nxt;
         r_dphase_valid <= w_dphase_nxt;
         r_wait_cnt     <= w_wait_nxt;
      end
   end

   // Address-phase mux. HTRANS is forced IDLE while reset is asserted so the
   // slave never sees a transfer from a master that is itself being reset.
   assign s_HTRANS    = !HRESETn ? LP_IDLE : (r_owner ? m1_HTRANS : m0_HTRANS);
   assign s_HADDR     = r_owner ? m1_HADDR     : m0_HADDR;
   assign s_HWRITE    = r_owner ? m1_HWRITE    : m0_HWRITE;
   assign s_HSIZE     = r_owner ? m1_HSIZE     : m0_HSIZE;
   assign s_HBURST    = r_owner ? m1_HBURST    : m0_HBURST;
   assign s_HPROT     = r_owner ? m1_HPROT     : m0_HPROT;
   assign s_HMASTLOCK = r_owner ? m1_HMASTLOCK : m0_HMASTLOCK;
   // The data phase always belongs to the current owner, because ownership
   // only changes when the outgoing owner has no data phase pending.
   assign s_HWDATA    = r_owner ? m1_HWDATA    : m0_HWDATA;

   assign m0_HRDATA = s_HRDATA;
   assign m1_HRDATA = s_HRDATA;

   // Owner follows the slave; a non-owner is stalled only while it requests.
   always_comb begin
      m0_HREADY = 1'b1;
      m0_HRESP  = LP_OKAY;
      m1_HREADY = 1'b1;
      m1_HRESP  = LP_OKAY;
      if (HRESETn) begin
         if (r_owner == 1'b0) begin
            m0_HREADY = s_HREADY;
            m0_HRESP  = r_dphase_valid ? s_HRESP : LP_OKAY;
            m1_HREADY = ~w_req1;
         end else begin
            m1_HREADY = s_HREADY;
            m1_HRESP  = r_dphase_valid ? s_HRESP : LP_OKAY;
            m0_HREADY = ~w_req0;
         end
      end
   end

   assign owner_o  = r_owner;
   assign starve_o = HRESETn && (r_wait_cnt >= LP_LIMIT);

endmodule

// File: tb/tb_ahb_lite_arbiter_2m.sv
// ----------------------------------------------------------------------------
// tb_ahb_lite_arbiter_2m
//
// Directed bench for ahb_lite_arbiter_2m. Inputs change 1 ns after a rising
// HCLK; outputs are checked at the falling edge. Expected values are written
// out by hand for each cycle.
// ----------------------------------------------------------------------------
module tb_ahb_lite_arbiter_2m;

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] NONSEQ = 2'b10;
   localparam logic [1:0] SEQ    = 2'b11;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] ERROR  = 2'b01;

   // ------------------------------------------------------------- clock/reset
   logic HCLK = 1'b0;
   logic HRESETn;
   always #5 HCLK = ~HCLK;

   logic [1:0]  m0_HTRANS, m1_HTRANS;
   logic [31:0] m0_HADDR, m1_HADDR;
   logic        m0_HWRITE, m1_HWRITE;
   logic [2:0]  m0_HSIZE, m1_HSIZE;
   logic [2:0]  m0_HBURST, m1_HBURST;
   logic [3:0]  m0_HPROT, m1_HPROT;
   logic        m0_HMASTLOCK, m1_HMASTLOCK;
   logic [31:0] m0_HWDATA, m1_HWDATA;
   logic        m0_HREADY, m1_HREADY;
   logic [1:0]  m0_HRESP, m1_HRESP;
   logic [31:0] m0_HRDATA, m1_HRDATA;
   logic [1:0]  s_HTRANS;
   logic [31:0] s_HADDR;
   logic        s_HWRITE;
   logic [2:0]  s_HSIZE;
   logic [2:0]  s_HBURST;
   logic [3:0]  s_HPROT;
   logic        s_HMASTLOCK;
   logic [31:0] s_HWDATA;
   logic        s_HREADY;
   logic [1:0]  s_HRESP;
   logic [31:0] s_HRDATA;
   logic        owner_o;
   logic        starve_o;

   ahb_lite_arbiter_2m #(.PARK_MASTER(1'b0), .STARVE_LIMIT(16)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .m0_HTRANS(m0_HTRANS), .m0_HADDR(m0_HADDR), .m0_HWRITE(m0_HWRITE),
      .m0_HSIZE(m0_HSIZE), .m0_HBURST(m0_HBURST), .m0_HPROT(m0_HPROT),
      .m0_HMASTLOCK(m0_HMASTLOCK), .m0_HWDATA(m0_HWDATA),
      .m0_HREADY(m0_HREADY), .m0_HRESP(m0_HRESP), .m0_HRDATA(m0_HRDATA),
      .m1_HTRANS(m1_HTRANS), .m1_HADDR(m1_HADDR), .m1_HWRITE(m1_HWRITE),
      .m1_HSIZE(m1_HSIZE), .m1_HBURST(m1_HBURST), .m1_HPROT(m1_HPROT),
      .m1_HMASTLOCK(m1_HMASTLOCK), .m1_HWDATA(m1_HWDATA),
      .m1_HREADY(m1_HREADY), .m1_HRESP(m1_HRESP), .m1_HRDATA(m1_HRDATA),
      .s_HTRANS(s_HTRANS), .s_HADDR(s_HADDR), .s_HWRITE(s_HWRITE),
      .s_HSIZE(s_HSIZE), .s_HBURST(s_HBURST), .s_HPROT(s_HPROT),
      .s_HMASTLOCK(s_HMASTLOCK), .s_HWDATA(s_HWDATA),
      .s_HREADY(s_HREADY), .s_HRESP(s_HRESP), .s_HRDATA(s_HRDATA),
      .owner_o(owner_o), .starve_o(starve_o)
   );

   // ------------------------------------------------------------- checking
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------- driver tasks
   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic mid();
      @(negedge HCLK);
   endtask

   task automatic drv_m0(input logic [1:0] t, input logic [31:0] a, input logic w,
                         input logic [2:0] b, input logic lk);
      m0_HTRANS = t; m0_HADDR = a; m0_HWRITE = w; m0_HBURST = b; m0_HMASTLOCK = lk;
   endtask

   task automatic drv_m1(input logic [1:0] t, input logic [31:0] a, input logic w);
      m1_HTRANS = t; m1_HADDR = a; m1_HWRITE = w;
   endtask

   task automatic drv_s(input logic rdy, input logic [1:0] resp, input logic [31:0] rd);
      s_HREADY = rdy; s_HRESP = resp; s_HRDATA = rd;
   endtask

   // ------------------------------------------------------------- stimulus
   initial begin
      HRESETn = 1'b0;
      drv_m0(NONSEQ, 32'h0, 1'b0, 3'd0, 1'b0);
      drv_m1(IDLE, 32'h0, 1'b0);
      m0_HSIZE = 3'd2; m1_HSIZE = 3'd2; m1_HBURST = 3'd0; m1_HMASTLOCK = 1'b0;
      m0_HPROT = 4'h3; m1_HPROT = 4'hA;
      m0_HWDATA = 32'h1111_1111; m1_HWDATA = 32'h0;
      drv_s(1'b0, OKAY, 32'h0);

      // Reset: forced idle/ready even with m0 requesting and slave not ready.
      mid();
      check("rst_owner", owner_o, 0);
      check("rst_s_htrans", s_HTRANS, IDLE);
      check("rst_m0_hready", m0_HREADY, 1);
      check("rst_m1_hready", m1_HREADY, 1);
      check("rst_m0_hresp", m0_HRESP, OKAY);
      check("rst_starve", starve_o, 0);
      check("rst_s_hwdata", s_HWDATA, 32'h1111_1111);
      tick();
      HRESETn = 1'b1;

      // m1 single write while m0 idle.
      drv_m0(IDLE, 32'h0, 1'b0, 3'd0, 1'b0);
      drv_m1(NONSEQ, 32'h0000_1000, 1'b1);
      drv_s(1'b1, OKAY, 32'h0);
      mid();
      check("wr_c0_owner", owner_o, 0);
      check("wr_c0_m1_stall", m1_HREADY, 0);
      check("wr_c0_s_htrans", s_HTRANS, IDLE);
      tick();
      mid();
      check("wr_c1_owner", owner_o, 1);
      check("wr_c1_s_haddr", s_HADDR, 32'h0000_1000);
      check("wr_c1_s_htrans", s_HTRANS, NONSEQ);
      check("wr_c1_s_hwrite", s_HWRITE, 1);
      check("wr_c1_s_hprot", s_HPROT, 4'hA);
      check("wr_c1_m1_hready", m1_HREADY, 1);
      tick();
      drv_m1(IDLE, 32'h0, 1'b0);
      m1_HWDATA = 32'hDEAD_BEEF;
      drv_s(1'b0, OKAY, 32'h0);
      mid();
      check("wr_c2_s_hwdata", s_HWDATA, 32'hDEAD_BEEF);
      check("wr_c2_m1_hready", m1_HREADY, 0);
      tick();
      drv_s(1'b1, OKAY, 32'h0);
      mid();
      check("wr_c3_m1_hready", m1_HREADY, 1);
      check("wr_c3_m1_hresp", m1_HRESP, OKAY);
      check("wr_c3_owner", owner_o, 1);
      tick();
      mid();
      check("wr_park_owner", owner_o, 0);

      // m0 INCR4 read with two wait states on beat 2; m1 requests mid-burst.
      tick();
      drv_m0(NONSEQ, 32'h2000, 1'b0, 3'd3, 1'b0);
      mid();
      check("b_c0_s_haddr", s_HADDR, 32'h2000);
      check("b_c0_s_hburst", s_HBURST, 3'd3);
      tick();
      drv_m0(SEQ, 32'h2004, 1'b0, 3'd3, 1'b0);
      drv_m1(NONSEQ, 32'h3000, 1'b0);
      drv_s(1'b1, OKAY, 32'hA0);
      mid();
      check("b_beat1", m0_HRDATA, 32'hA0);
      check("b_c1_m0_hready", m0_HREADY, 1);
      check("b_c1_m1_stall", m1_HREADY, 0);
      tick();
      drv_m0(SEQ, 32'h2008, 1'b0, 3'd3, 1'b0);
      drv_s(1'b0, OKAY, 32'h0);
      for (int i = 0; i < 2; i++) begin
         mid();
         check("b_wait_m0_hready", m0_HREADY, 0);
         check("b_wait_m1_stall", m1_HREADY, 0);
         check("b_wait_owner", owner_o, 0);
         tick();
      end
      drv_s(1'b1, OKAY, 32'hA1);
      mid();
      check("b_beat2", m0_HRDATA, 32'hA1);
      check("b_beat2_hready", m0_HREADY, 1);
      check("b_c4_s_haddr", s_HADDR, 32'h2008);
      tick();
      drv_m0(SEQ, 32'h200C, 1'b0, 3'd3, 1'b0);
      drv_s(1'b1, OKAY, 32'hA2);
      mid();
      check("b_beat3", m0_HRDATA, 32'hA2);
      check("b_c5_owner", owner_o, 0);
      tick();
      drv_m0(IDLE, 32'h0, 1'b0, 3'd0, 1'b0);
      drv_s(1'b1, OKAY, 32'hA3);
      mid();
      check("b_beat4", m0_HRDATA, 32'hA3);
      check("b_c6_m1_stall", m1_HREADY, 0);
      check("b_c6_owner", owner_o, 0);
      tick();
      mid();
      check("b_c7_owner", owner_o, 1);
      check("b_c7_s_haddr", s_HADDR, 32'h3000);
      check("b_c7_m1_hready", m1_HREADY, 1);
      tick();
      drv_m1(IDLE, 32'h0, 1'b0);
      drv_s(1'b1, OKAY, 32'hB0);
      mid();
      check("b_m1_rdata", m1_HRDATA, 32'hB0);
      tick();
      mid();
      check("b_park_owner", owner_o, 0);
      tick();

      // Locked m0 with interleaved IDLE cycles; m1 waits and starves.
      drv_m1(NONSEQ, 32'h7000, 1'b0);
      for (int i = 0; i < 20; i++) begin
         drv_m0((i % 2 == 0) ? NONSEQ : IDLE, 32'h6000, 1'b0, 3'd0, 1'b1);
         mid();
         check("lk_owner", owner_o, 0);
         check("lk_m1_stall", m1_HREADY, 0);
         check("lk_starve", starve_o, (i >= 16) ? 1 : 0);
         tick();
      end
      drv_m0(IDLE, 32'h0, 1'b0, 3'd0, 1'b0);
      mid();
      check("lk_unlock_starve", starve_o, 1);
      check("lk_unlock_owner", owner_o, 0);
      tick();
      mid();
      check("lk_ho_owner", owner_o, 1);
      check("lk_ho_starve", starve_o, 0);
      check("lk_ho_s_haddr", s_HADDR, 32'h7000);
      tick();

      // Two-cycle ERROR on m1's transfer; m0 waiting takes over after it.
      drv_m1(IDLE, 32'h0, 1'b0);
      drv_m0(NONSEQ, 32'h4000, 1'b0, 3'd0, 1'b0);
      drv_s(1'b0, ERROR, 32'h0);
      mid();
      check("err1_m1_hresp", m1_HRESP, ERROR);
      check("err1_m1_hready", m1_HREADY, 0);
      check("err1_m0_hresp", m0_HRESP, OKAY);
      check("err1_m0_stall", m0_HREADY, 0);
      tick();
      drv_s(1'b1, ERROR, 32'h0);
      mid();
      check("err2_m1_hresp", m1_HRESP, ERROR);
      check("err2_m1_hready", m1_HREADY, 1);
      check("err2_m0_hresp", m0_HRESP, OKAY);
      tick();
      drv_s(1'b1, OKAY, 32'h0);
      drv_m1(NONSEQ, 32'h5000, 1'b0);
      mid();
      check("err_ho_owner", owner_o, 0);
      check("err_ho_s_haddr", s_HADDR, 32'h4000);
      check("err_ho_m0_hready", m0_HREADY, 1);
      check("err_ho_m0_hresp", m0_HRESP, OKAY);
      tick();

      // m1 gets the bus, then reset hits in the middle of its data phase.
      drv_m0(IDLE, 32'h0, 1'b0, 3'd0, 1'b0);
      mid();
      check("r_c0_owner", owner_o, 0);
      tick();
      mid();
      check("r_c1_owner", owner_o, 1);
      check("r_c1_s_haddr", s_HADDR, 32'h5000);
      tick();
      drv_m1(NONSEQ, 32'h5004, 1'b0);
      drv_s(1'b0, OKAY, 32'h0);
      #2;
      check("r_pre_m1_hready", m1_HREADY, 0);
      check("r_pre_s_htrans", s_HTRANS, NONSEQ);
      HRESETn = 1'b0;
      #1;
      check("r_async_owner", owner_o, 0);
      check("r_async_s_htrans", s_HTRANS, IDLE);
      check("r_async_m0_hready", m0_HREADY, 1);
      check("r_async_m1_hready", m1_HREADY, 1);
      check("r_async_m1_hresp", m1_HRESP, OKAY);
      check("r_async_starve", starve_o, 0);
      drv_m1(IDLE, 32'h0, 1'b0);
      drv_s(1'b1, OKAY, 32'h0);
      tick();
      HRESETn = 1'b1;
      drv_s(1'b1, ERROR, 32'h0);
      mid();
      check("r_post_owner", owner_o, 0);
      check("r_post_m0_hresp", m0_HRESP, OKAY);
      check("r_post_m0_hready", m0_HREADY, 1);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
